// File: rtl/spi_reg_bank.sv
// Mode-0 SPI slave register bank with all SPI pins oversampled into clk.
// Optional read-back path enabled by defining SPI_REG_READBACK_EN.
module spi_reg_bank #(
  parameter int              DATA_W      = 8,
  parameter int              ADDR_W      = 7,
  parameter int              NUM_REGS    = 5,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         cs_n,
  input  logic                         copi,
  output logic                         cipo,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int FLUSH   = SYNC_STAGES + 1;
  localparam int FL_W    = $clog2(FLUSH + 1);
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, copi_sync_reg;
  logic                   sclk_d_reg, cs_d_reg;
  logic [FL_W-1:0]        flush_cnt_reg;
  logic                   armed_reg;
  logic                   sclk_s, cs_s, copi_s;
  logic                   sclk_rise, cs_fall, cs_rise;

  state_t                 state_reg, state_next;
  logic                   clear_en, shift_en, commit_en;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [FRAME_W-1:0]     rx_shift_reg;
  logic                   rx_rw;
  logic [ADDR_W-1:0]      rx_addr;
  logic [DATA_W-1:0]      rx_data;
  logic                   frame_ok, wr_hit;
  logic [NUM_REGS-1:0]    wr_sel;
  logic [NUM_REGS-1:0]    wr_strobe_reg;
  logic                   frame_err_reg;
  logic [DATA_W-1:0]      reg_word [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '1;
      copi_sync_reg <= '0;
      sclk_d_reg    <= 1'b0;
      cs_d_reg      <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
      copi_sync_reg <= {copi_sync_reg[SYNC_STAGES-2:0], copi};
      sclk_d_reg    <= sclk_sync_reg[SYNC_STAGES-1];
      cs_d_reg      <= cs_sync_reg[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
  assign copi_s = copi_sync_reg[SYNC_STAGES-1];

  // A chip select already low at reset release must not look like a new frame:
  // cs_fall is only honoured after cs_n has been seen high past the flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_reg <= '0;
      armed_reg     <= 1'b0;
    end else begin
      if (flush_cnt_reg != FL_W'(FLUSH))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      armed_reg <= armed_reg | ((flush_cnt_reg == FL_W'(FLUSH)) & cs_s & cs_d_reg);
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign cs_fall   = armed_reg & cs_d_reg & ~cs_s;
  assign cs_rise   = cs_s & ~cs_d_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (cs_fall) state_next = ST_SHIFT;
      ST_SHIFT:  if (cs_rise) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

`ifdef SPI_REG_READBACK_EN
  logic sclk_fall, fall_en;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
`endif

  always_comb begin
    clear_en  = (state_reg == ST_IDLE) & cs_fall;
    shift_en  = (state_reg == ST_SHIFT) & sclk_rise & ~cs_rise;
    commit_en = (state_reg == ST_COMMIT);
`ifdef SPI_REG_READBACK_EN
    fall_en   = (state_reg == ST_SHIFT) & sclk_fall & ~cs_rise;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
    end else if (clear_en) begin
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
    end else if (shift_en) begin
      rx_shift_reg <= {rx_shift_reg[FRAME_W-2:0], copi_s};
      if (bit_cnt_reg != CNT_W'(FRAME_W + 1))
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
    end
  end

  assign rx_rw    = rx_shift_reg[FRAME_W-1];
  assign rx_addr  = rx_shift_reg[FRAME_W-2 -: ADDR_W];
  assign rx_data  = rx_shift_reg[DATA_W-1:0];
  assign frame_ok = (bit_cnt_reg == CNT_W'(FRAME_W));
  assign wr_hit   = commit_en & frame_ok & rx_rw & ({1'b0, rx_addr} < NUM_REGS_W);

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] value_reg;

      assign wr_sel[gi] = wr_hit & (rx_addr == ADDR_W'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst)             value_reg <= RESET_VAL;
        else if (wr_sel[gi]) value_reg <= rx_data;
      end

      assign reg_word[gi]                 = value_reg;
      assign regs[gi*DATA_W +: DATA_W]    = value_reg;
    end
  endgenerate

  // Strobe and frame error are registered so they line up with the register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_strobe_reg <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      wr_strobe_reg <= wr_sel;
      frame_err_reg <= commit_en & ~frame_ok;
    end
  end

  assign wr_strobe = wr_strobe_reg;
  assign frame_err = frame_err_reg;

`ifdef SPI_REG_READBACK_EN
  logic [ADDR_W:0]   hdr;
  logic              load_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] tx_shift_reg;
  logic              rd_active_reg;
  logic              cipo_reg;

  // Header completes on the rise that shifts in the last address bit.
  assign hdr     = {rx_shift_reg[ADDR_W-1:0], copi_s};
  assign load_en = shift_en & (bit_cnt_reg == CNT_W'(ADDR_W));

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (hdr[ADDR_W-1:0] == ADDR_W'(i)) rd_word = reg_word[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_reg  <= '0;
      rd_active_reg <= 1'b0;
      cipo_reg      <= 1'b0;
    end else if (state_next != ST_SHIFT || clear_en) begin
      rd_active_reg <= 1'b0;
      cipo_reg      <= 1'b0;
    end else if (load_en) begin
      tx_shift_reg  <= rd_word;
      rd_active_reg <= ~hdr[ADDR_W];
    end else if (fall_en && rd_active_reg) begin
      cipo_reg     <= tx_shift_reg[DATA_W-1];
      tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo = cipo_reg;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised bench for spi_reg_bank: bit-banged SPI frames checked against an
// array model of the register file, write strobes and frame errors.
module tb_spi_reg_bank;
  localparam int DW = 8, AW = 7, NR = 5, SS = 2, FW = 1 + AW + DW;
`ifdef SPI_REG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, copi = 1'b0;
  logic cipo, frame_err;
  logic [NR*DW-1:0] regs;
  logic [NR-1:0] wr_strobe;

  spi_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .SYNC_STAGES(SS),
                 .RESET_VAL('0)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .copi(copi), .cipo(cipo),
    .regs(regs), .wr_strobe(wr_strobe), .frame_err(frame_err));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [DW-1:0] model [NR];
  int strobe_q[$];
  logic [DW-1:0] strobe_val_q[$];
  int err_cnt = 0, multi_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record every strobe cycle, and the register value visible in that same cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(wr_strobe) > 1) multi_cnt++;
      for (int i = 0; i < NR; i++)
        if (wr_strobe[i]) begin
          strobe_q.push_back(i);
          strobe_val_q.push_back(regs[i*DW +: DW]);
        end
      if (frame_err) err_cnt++;
    end
  end

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int half, output logic r);
    copi = b;
    wait_clk(half);
    sclk = 1'b1;
    r = cipo;
    wait_clk(half);
    sclk = 1'b0;
  endtask

  task automatic clear_mon();
    strobe_q.delete();
    strobe_val_q.delete();
    err_cnt   = 0;
    multi_cnt = 0;
  endtask

  // One frame, cs_n high for three sclk periods afterwards, then score it.
  task automatic do_frame(input string name, input int nbits, input logic [31:0] word, input int half);
    logic [31:0] rx;
    logic r;
    bit ok, rw, wr;
    int addr;
    logic [DW-1:0] data, exp_rd;
    clear_mon();
    rx = '0;
    cs_n = 1'b0;
    wait_clk(half);
    for (int b = nbits - 1; b >= 0; b--) begin
      send_bit(word[b], half, r);
      rx = {rx[30:0], r};
    end
    wait_clk(half);
    cs_n = 1'b1;
    copi = 1'b0;
    wait_clk(6 * half);

    ok   = (nbits == FW);
    rw   = word[FW-1];
    addr = int'(word[FW-2 -: AW]);
    data = word[DW-1:0];
    wr   = ok && rw && (addr < NR);
    exp_rd = (RB && addr < NR) ? model[addr % NR] : '0;
    if (wr) model[addr] = data;

    $display("frame %s len=%0d word=%0h half=%0d rx=%0h", name, nbits, word, half, rx[DW-1:0]);
    check({name, " strobes"}, strobe_q.size(), wr ? 1 : 0);
    check({name, " multi"}, multi_cnt, 0);
    check({name, " frame_err"}, err_cnt, ok ? 0 : 1);
    if (strobe_q.size() == 1) begin
      check({name, " strobe_addr"}, strobe_q[0], addr);
      check({name, " strobe_val"}, strobe_val_q[0], data);
    end
    check({name, " regs"}, regs, model_vec());
    check({name, " cipo_idle"}, cipo, 0);
    if (ok && !rw) check({name, " rdata"}, rx[DW-1:0], exp_rd);
  endtask

  function automatic logic [31:0] wframe(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return 32'({rw, a, d});
  endfunction

  initial begin
    logic r;
    int half, len, sel;
    logic [31:0] w;
    for (int i = 0; i < NR; i++) model[i] = '0;

    wait_clk(3);
    check("rst regs", regs, 0);
    check("rst cipo", cipo, 0);
    check("rst strobe", wr_strobe, 0);
    check("rst frame_err", frame_err, 0);
    rst = 1'b0;
    wait_clk(10);

    // Reset mid-frame, with cs_n still low when reset releases.
    clear_mon();
    cs_n = 1'b0;
    wait_clk(8);
    for (int b = 0; b < 5; b++) send_bit(1'b1, 8, r);
    rst = 1'b1;
    wait_clk(3);
    check("midrst regs", regs, 0);
    rst = 1'b0;
    wait_clk(6);
    w = wframe(1'b1, 7'h02, 8'h77);
    for (int b = FW - 1; b >= 0; b--) send_bit(w[b], 8, r);
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(48);
    $display("frame midrst partial ignored");
    check("midrst strobes", strobe_q.size(), 0);
    check("midrst frame_err", err_cnt, 0);
    check("midrst regs2", regs, 0);

    do_frame("wr2", FW, wframe(1'b1, 7'h02, 8'hA5), 8);
    do_frame("wr0", FW, wframe(1'b1, 7'h00, 8'h3C), 8);
    do_frame("wr5", FW, wframe(1'b1, 7'h05, 8'hFF), 8);
    do_frame("short", 10, 32'h2A5, 8);
    do_frame("long", 17, {wframe(1'b1, 7'h03, 8'h5A), 1'b1}, 8);
    do_frame("wr1", FW, wframe(1'b1, 7'h01, 8'h96), 8);
    do_frame("rd1", FW, wframe(1'b0, 7'h01, 8'h00), 8);
    do_frame("rd7f", FW, wframe(1'b0, 7'h7F, 8'h00), 8);
    do_frame("b2b_a", FW, wframe(1'b1, 7'h03, 8'h11), 8);
    do_frame("b2b_b", FW, wframe(1'b1, 7'h04, 8'h22), 8);
    do_frame("b2b8_a", FW, wframe(1'b1, 7'h03, 8'hC3), 4);
    do_frame("b2b8_b", FW, wframe(1'b1, 7'h04, 8'h3C), 4);
    do_frame("rd4_8x", FW, wframe(1'b0, 7'h04, 8'h00), 4);

    for (int n = 0; n < 30; n++) begin
      half = ($urandom_range(0, 1) != 0) ? 4 : 8;
      sel  = $urandom_range(0, 9);
      len  = (sel == 0) ? $urandom_range(1, FW - 1) : (sel == 1) ? $urandom_range(FW + 1, FW + 2) : FW;
      w = wframe($urandom_range(0, 1) != 0,
                 ($urandom_range(0, 7) == 7) ? 7'h7F : 7'($urandom_range(0, 6)),
                 8'($urandom));
      if (len != FW) w = $urandom & ((32'h1 << len) - 1);
      do_frame("rand", len, w, half);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
Parametrised successor to the team's SPI register peripheral: a mode-0 SPI slave with a configurable register file. All SPI pins are oversampled and synchronised into the system clock domain, so every register and FSM runs on clk alone. Registers hold their values between transactions, and the block adds a real read-back path, per-register write strobes and frame-error detection. It sits between the top-level SPI pins and the downstream PWM/config logic.

Parameters:
DATA_W, 8, register width and data-field width in bits
ADDR_W, 7, address-field width in bits
NUM_REGS, 5, number of implemented registers (1..2**ADDR_W)
SYNC_STAGES, 2, flip-flop stages on each of sclk/cs_n/copi (minimum 2)
RESET_VAL, 0, reset value of every register, DATA_W bits

Ports:
clk  in  1  system clock, required to be at least 8x the sclk frequency
rst  in  1  asynchronous, active-high reset
sclk  in  1  SPI clock from the controller (asynchronous)
cs_n  in  1  SPI chip select, active-low (asynchronous)
copi  in  1  controller-out data (asynchronous)
cipo  out  1  controller-in data, registered
regs  out  NUM_REGS*DATA_W  flattened register file, reg i at [i*DATA_W +: DATA_W]
wr_strobe  out  NUM_REGS  one-clk pulse on the register just written
frame_err  out  1  one-clk pulse when a frame is aborted or malformed

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: regs all RESET_VAL, cipo 0, wr_strobe 0, frame_err 0, FSM IDLE.
- Reset also sets the sclk and copi synchroniser flops to 0 and the cs_n synchroniser flops to 1.
- Frame format, MSB first: FRAME_W = 1+ADDR_W+DATA_W bits, made up of the rw bit (1=write), then addr, then data.
- Edge detection: sclk_rise/sclk_fall come from the last synchroniser stage versus one extra delayed flop; cs_fall/cs_rise are detected the same way.
- FSM IDLE:
  - Ignores sclk.
  - On cs_fall, clears bit_cnt and the shift register, then goes to SHIFT.
  - A cs_n held low when reset releases gives no cs_fall, so that partial frame is ignored.
- FSM SHIFT:
  - On each sclk_rise: shift in synced copi; bit_cnt increments and saturates at FRAME_W+1.
  - On cs_rise: go to COMMIT. Any sclk edge in the same cycle as cs_rise is discarded.
- FSM COMMIT (exactly one cycle), then IDLE:
  - bit_cnt==FRAME_W, rw=1, addr<NUM_REGS: reg[addr] takes the data field. The new value and the wr_strobe[addr] pulse appear on the same clk edge.
  - bit_cnt==FRAME_W, rw=1, addr>=NUM_REGS: no write, no strobe, no error.
  - bit_cnt==FRAME_W, rw=0: no state change.
  - bit_cnt!=FRAME_W (short or over-length frame): frame_err pulses one cycle and nothing is written.
- Write latency: reg update lands SYNC_STAGES+2 clk cycles after cs_n rises at the pin, with +1 cycle of sampling uncertainty.
- Read path:
  - When bit_cnt reaches 1+ADDR_W with rw=0, tx_shift loads reg[addr], or 0 if addr>=NUM_REGS.
  - On each following sclk_fall, cipo takes tx_shift MSB and tx_shift shifts left.
  - The first data bit is therefore valid before the first data-phase sclk_rise.
  - cipo returns to 0 in IDLE/COMMIT and during write frames.
- Register read data is a snapshot taken at address capture, so a concurrent write cannot tear it.
- Clock-ratio violation (clk below 8x sclk) is unsupported; the bench does not test it.

Optional Feature:
Macro SPI_REG_READBACK_EN.
- Defined: read path as described above.
- Undefined:
  - tx_shift and its logic are removed and cipo is tied to 0.
  - rw=0 frames of correct length complete silently.
  - Write and error behaviour are unchanged.

Test Plan:
- Reset, then read regs -> all fields 0x00, cipo=0, wr_strobe=0. Assert rst mid-frame -> regs stay RESET_VAL and the FSM returns to IDLE.
- Write frame rw=1 addr=0x02 data=0xA5 -> regs[2]=0xA5, wr_strobe=5'b00100 for exactly 1 clk, other regs unchanged. Then write addr=0x00 data=0x3C -> reg0=0x3C and reg2 still 0xA5.
- Write addr=0x05 (>=NUM_REGS) data=0xFF -> no reg change, wr_strobe=0, frame_err=0.
- Short frame (10 sclk pulses, then cs_n high) and long frame (17 pulses) -> frame_err pulses once each, no reg change.
- With readback enabled, write addr=0x01 data=0x96, then read frame rw=0 addr=0x01 -> 8 data bits sampled on sclk rising = 0x96. Read addr=0x7F -> 0x00.
- Back-to-back writes with cs_n high for 3 sclk periods -> both commits land in order with two separate strobes. Repeat at clk/sclk = 8 -> still correct.
